// File: rtl/ret_addr_stack.sv
// ret_addr_stack: LIFO of {mode, addr}; ports clk, reset(async low), push, pop, interrupt, pc_addr, clr_err -> out, top_int, empty, full, count, overflow, underflow
module ret_addr_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              interrupt,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] out,
  output logic              top_int,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [ADDR_W:0] mem [DEPTH];
  logic [CNT_W-1:0] top_ptr, wr_ptr, count_nxt;
  logic [ADDR_W:0] top;
  logic wr_en, ovf_set, unf_set;
  always_comb begin
    top_ptr = count - CNT_W'(1);
    wr_en = push && (pop || !full);
    wr_ptr = (pop && !empty) ? top_ptr : count;
    ovf_set = push && !pop && full;
    unf_set = !push && pop && empty;
    count_nxt = (push && !pop && !full) ? count + CNT_W'(1) :
                (push && pop && empty) ? CNT_W'(1) :
                (!push && pop && !empty) ? top_ptr : count;
    top = empty ? '0 : mem[top_ptr[IDX_W-1:0]];
    top_int = top[ADDR_W];
    out = empty ? '0 : top[ADDR_W] ? top[ADDR_W-1:0] : top[ADDR_W-1:0] + ADDR_W'(1);
  end
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_nxt;
      overflow <= ovf_set || (overflow && !clr_err);
      underflow <= unf_set || (underflow && !clr_err);
      if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= {interrupt, pc_addr};
    end
  end
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: table-driven and directed checks of ret_addr_stack
module tb_ret_addr_stack;
  logic clk = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0, interrupt = 1'b0, clr_err = 1'b0;
  logic [9:0] pc_addr = '0, out;
  logic top_int, empty, full, overflow, underflow;
  logic [4:0] count;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic p, po, i;
    logic [9:0] a;
    logic c;
    logic [9:0] eo;
    logic ei;
    int ec;
    logic eov, eun;
  } vec_t;
  vec_t v [15];
  ret_addr_stack dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .interrupt(interrupt),
    .pc_addr(pc_addr), .clr_err(clr_err), .out(out), .top_int(top_int),
    .empty(empty), .full(full), .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [9:0] eo, input logic ei, input int ec,
                       input logic eov, input logic eun);
    logic [19:0] got, exp;
    got = {out, top_int, empty, full, count, overflow, underflow};
    exp = {eo, ei, ec == 0, ec == 16, 5'(ec), eov, eun};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got out=%h int=%b e=%b f=%b cnt=%0d ovf=%b unf=%b, want out=%h int=%b cnt=%0d ovf=%b unf=%b",
               name, out, top_int, empty, full, count, overflow, underflow, eo, ei, ec, eov, eun);
    end
  endtask
  task automatic step(input logic p, input logic po, input logic i, input logic [9:0] a, input logic c);
    push = p; pop = po; interrupt = i; pc_addr = a; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; interrupt = 1'b0; pc_addr = '0; clr_err = 1'b0;
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 1'b0, 10'h100, 1'b0, 10'h101, 1'b0, 1, 1'b0, 1'b0};
    v[1]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 1'b0, 1'b0};
    v[2]  = '{1'b1, 1'b0, 1'b0, 10'h040, 1'b0, 10'h041, 1'b0, 1, 1'b0, 1'b0};
    v[3]  = '{1'b1, 1'b0, 1'b1, 10'h2A5, 1'b0, 10'h2A5, 1'b1, 2, 1'b0, 1'b0};
    v[4]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h041, 1'b0, 1, 1'b0, 1'b0};
    v[5]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 1'b0, 1'b0};
    v[6]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 1'b0, 1'b1};
    v[7]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 1'b0, 0, 1'b0, 1'b0};
    v[8]  = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h000, 1'b0, 0, 1'b0, 1'b1};
    v[9]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 1'b0, 0, 1'b0, 1'b0};
    v[10] = '{1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0, 10'h000, 1'b0, 1, 1'b0, 1'b0};
    v[11] = '{1'b1, 1'b1, 1'b1, 10'h123, 1'b0, 10'h123, 1'b1, 1, 1'b0, 1'b0};
    v[12] = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 1'b0, 1'b0};
    v[13] = '{1'b1, 1'b1, 1'b0, 10'h055, 1'b0, 10'h056, 1'b0, 1, 1'b0, 1'b0};
    v[14] = '{1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 10'h000, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step(v[k].p, v[k].po, v[k].i, v[k].a, v[k].c);
      check($sformatf("vec%0d", k), v[k].eo, v[k].ei, v[k].ec, v[k].eov, v[k].eun);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b0, 10'(k), 1'b0);
      check($sformatf("fill%0d", k), 10'(k + 1), 1'b0, k + 1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0);
    check("overflow_push", 10'h010, 1'b0, 16, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'h200, 1'b0);
    check("replace_full", 10'h200, 1'b1, 16, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
      check($sformatf("lifo_pop%0d", k), k == 16 ? 10'h000 : 10'(16 - k), 1'b0, 16 - k, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
    check("clr_overflow", 10'h000, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) step(1'b1, 1'b0, 1'b0, 10'(k), 1'b0);
    for (int k = 0; k < 11; k++) step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    check("pre_reset", 10'h005, 1'b0, 5, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset", 10'h000, 1'b0, 0, 1'b0, 1'b0);
    push = 1'b1; pc_addr = 10'h077;
    @(posedge clk);
    #1;
    check("push_in_reset", 10'h000, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    push = 1'b0; pc_addr = '0;
    reset = 1'b1;
    #1;
    check("after_release", 10'h000, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 10'h0AA, 1'b0);
    check("push_after_reset", 10'h0AB, 1'b0, 1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
